// File: rtl/sc_pkg.sv
// sc_pkg: shared definitions for the slow-control transmit path.
//   - one-hot state encodings for the TX arbiter FSM
//   - default watchdog timeout
//   - field widths (ports, IPs, payload, source index)
//   - sc_wrap_idx: reduce (index + offset) back into 0..n-1
package sc_pkg;

    localparam int SC_PORT_W          = 16;
    localparam int SC_IP_W            = 32;
    localparam int SC_DATA_W          = 8;
    localparam int SC_IDX_W           = 3;
    localparam int SC_MAX_SRC         = 8;
    localparam int SC_WD_W            = 16;
    localparam int SC_TIMEOUT_DEFAULT = 65535;

    localparam logic [3:0] SC_ST_IDLE  = 4'b0001;
    localparam logic [3:0] SC_ST_REQ   = 4'b0010;
    localparam logic [3:0] SC_ST_GRANT = 4'b0100;
    localparam logic [3:0] SC_ST_GAP   = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE  = SC_ST_IDLE,
        ST_REQ   = SC_ST_REQ,
        ST_GRANT = SC_ST_GRANT,
        ST_GAP   = SC_ST_GAP
    } sc_state_t;

    // sum is always < 2*n, so a single conditional subtract wraps it.
    function automatic logic [SC_IDX_W-1:0] sc_wrap_idx(input logic [SC_IDX_W:0] sum,
                                                        input int n);
        logic [SC_IDX_W:0] w;
        w = (int'(sum) >= n) ? sum - (SC_IDX_W+1)'(n) : sum;
        return w[SC_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/sc_rr_pick.sv
// sc_rr_pick: combinational round-robin requester finder.
//   req      : request vector, one bit per source
//   last_idx : index of the most recently served source
//   winner   : first requester strictly after last_idx, wrapping modulo N_SRC
//   valid    : at least one request is present
module sc_rr_pick
    import sc_pkg::*;
#(
    parameter int N_SRC = 3
) (
    input  logic [N_SRC-1:0]    req,
    input  logic [SC_IDX_W-1:0] last_idx,
    output logic [SC_IDX_W-1:0] winner,
    output logic                valid
);

    logic [SC_MAX_SRC-1:0] req_pad;
    logic [SC_IDX_W-1:0]   cand [N_SRC];
    logic [N_SRC-1:0]      hit;

    // Pad to the full index range so a 3-bit index always selects in range.
    generate
        for (genvar gi = 0; gi < SC_MAX_SRC; gi++) begin : g_pad
            if (gi < N_SRC) begin : g_real
                assign req_pad[gi] = req[gi];
            end else begin : g_zero
                assign req_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // cand[k] is the source visited k+1 steps after last_idx.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cand
            assign cand[gi] = sc_wrap_idx({1'b0, last_idx} + (SC_IDX_W+1)'(gi + 1), N_SRC);
            assign hit[gi]  = req_pad[cand[gi]];
        end
    endgenerate

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_tx_arbiter.sv
// sc_tx_arbiter: round-robin arbiter sharing the UDP TX engine among N_SRC
// slow-control reply sources, with a grant watchdog.
//   clk, rst                  : 125 MHz clock, asynchronous active-high reset
//   cfg_scport                : destination port substituted for sources >= 1
//   src_req/src_ack           : per-source request level / one-hot grant
//   src_start/src_done        : per-source frame start / frame complete
//   src_data, src_srcport, src_dstport, src_length, src_dstip : per-source fields
//   tx_req/tx_ack             : handshake with the UDP TX engine
//   tx_datardy                : engine data-ready, fanned out by the parent
//   tx_start, tx_done, tx_data, tx_srcport, tx_dstport, tx_length, tx_dstip :
//                               fields of the granted source (idle values otherwise)
//   grant_idx                 : current/last granted source
//   timeout_err               : one-cycle pulse when the watchdog ends a grant
module sc_tx_arbiter
    import sc_pkg::*;
#(
    parameter int   N_SRC           = 3,
    parameter int   TIMEOUT         = SC_TIMEOUT_DEFAULT,
    parameter logic SCPORT_OVERRIDE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SC_PORT_W-1:0]         cfg_scport,
    input  logic [N_SRC-1:0]             src_req,
    output logic [N_SRC-1:0]             src_ack,
    input  logic [N_SRC-1:0]             src_start,
    input  logic [N_SRC-1:0]             src_done,
    input  logic [SC_DATA_W*N_SRC-1:0]   src_data,
    input  logic [SC_PORT_W*N_SRC-1:0]   src_srcport,
    input  logic [SC_PORT_W*N_SRC-1:0]   src_dstport,
    input  logic [SC_PORT_W*N_SRC-1:0]   src_length,
    input  logic [SC_IP_W*N_SRC-1:0]     src_dstip,
    output logic                         tx_req,
    input  logic                         tx_ack,
    input  logic                         tx_datardy,
    output logic                         tx_start,
    output logic                         tx_done,
    output logic [SC_DATA_W-1:0]         tx_data,
    output logic [SC_PORT_W-1:0]         tx_srcport,
    output logic [SC_PORT_W-1:0]         tx_dstport,
    output logic [SC_PORT_W-1:0]         tx_length,
    output logic [SC_IP_W-1:0]           tx_dstip,
    output logic [SC_IDX_W-1:0]          grant_idx,
    output logic                         timeout_err
);

    localparam logic [SC_WD_W-1:0] WD_TC = SC_WD_W'(TIMEOUT - 1);

    sc_state_t             state_reg;
    logic [SC_IDX_W-1:0]   grant_idx_reg;
    logic [SC_IDX_W-1:0]   last_grant_reg;
    logic [N_SRC-1:0]      src_ack_reg;
    logic                  tx_req_reg;
    logic                  timeout_err_reg;
    logic [SC_WD_W-1:0]    wd_cnt_reg;

    logic [SC_IDX_W-1:0]   pick_winner;
    logic                  pick_valid;
    logic [N_SRC-1:0]      ack_onehot;

    // Per-source views padded to the full 3-bit index range.
    logic [SC_MAX_SRC-1:0] req_pad;
    logic [SC_MAX_SRC-1:0] start_pad;
    logic [SC_MAX_SRC-1:0] done_pad;
    logic [SC_DATA_W-1:0]  data_arr    [SC_MAX_SRC];
    logic [SC_PORT_W-1:0]  srcport_arr [SC_MAX_SRC];
    logic [SC_PORT_W-1:0]  dstport_arr [SC_MAX_SRC];
    logic [SC_PORT_W-1:0]  length_arr  [SC_MAX_SRC];
    logic [SC_IP_W-1:0]    dstip_arr   [SC_MAX_SRC];

    // The engine's data-ready is broadcast by the parent, not routed here.
    logic                  unused_tx_datardy;
    assign unused_tx_datardy = tx_datardy;

    generate
        for (genvar gi = 0; gi < SC_MAX_SRC; gi++) begin : g_src
            if (gi < N_SRC) begin : g_real
                assign req_pad[gi]     = src_req[gi];
                assign start_pad[gi]   = src_start[gi];
                assign done_pad[gi]    = src_done[gi];
                assign data_arr[gi]    = src_data[SC_DATA_W*gi +: SC_DATA_W];
                assign srcport_arr[gi] = src_srcport[SC_PORT_W*gi +: SC_PORT_W];
                assign dstport_arr[gi] = src_dstport[SC_PORT_W*gi +: SC_PORT_W];
                assign length_arr[gi]  = src_length[SC_PORT_W*gi +: SC_PORT_W];
                assign dstip_arr[gi]   = src_dstip[SC_IP_W*gi +: SC_IP_W];
            end else begin : g_zero
                assign req_pad[gi]     = 1'b0;
                assign start_pad[gi]   = 1'b0;
                assign done_pad[gi]    = 1'b0;
                assign data_arr[gi]    = '0;
                assign srcport_arr[gi] = '0;
                assign dstport_arr[gi] = '0;
                assign length_arr[gi]  = '0;
                assign dstip_arr[gi]   = '0;
            end
        end
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_onehot
            assign ack_onehot[gi] = (grant_idx_reg == SC_IDX_W'(gi));
        end
    endgenerate

    sc_rr_pick #(
        .N_SRC    (N_SRC)
    ) u_pick (
        .req      (src_req),
        .last_idx (last_grant_reg),
        .winner   (pick_winner),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            grant_idx_reg   <= '0;
            last_grant_reg  <= SC_IDX_W'(N_SRC - 1);
            src_ack_reg     <= '0;
            tx_req_reg      <= 1'b0;
            timeout_err_reg <= 1'b0;
            wd_cnt_reg      <= '0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_idx_reg <= pick_winner;
                        state_reg     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A withdrawn request abandons the attempt without
                    // advancing the round-robin pointer.
                    if (!req_pad[grant_idx_reg]) begin
                        tx_req_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end else if (tx_req_reg && tx_ack) begin
                        tx_req_reg  <= 1'b0;
                        src_ack_reg <= ack_onehot;
                        wd_cnt_reg  <= '0;
                        state_reg   <= ST_GRANT;
                    end else begin
                        tx_req_reg <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // done takes priority over the watchdog on the same cycle.
                    if (done_pad[grant_idx_reg]) begin
                        last_grant_reg <= grant_idx_reg;
                        src_ack_reg    <= '0;
                        state_reg      <= ST_GAP;
                    end else if (wd_cnt_reg == WD_TC) begin
                        timeout_err_reg <= 1'b1;
                        last_grant_reg  <= grant_idx_reg;
                        src_ack_reg     <= '0;
                        state_reg       <= ST_GAP;
                    end else if (wd_cnt_reg != '1) begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Engine-facing fields follow the granted source with no added latency;
    // outside a grant the engine sees an idle, completed interface.
    always_comb begin
        tx_start   = 1'b0;
        tx_done    = 1'b1;
        tx_data    = '0;
        tx_srcport = '0;
        tx_dstport = '0;
        tx_length  = '0;
        tx_dstip   = '0;
        if (state_reg == ST_GRANT) begin
            tx_start   = start_pad[grant_idx_reg];
            tx_done    = done_pad[grant_idx_reg];
            tx_data    = data_arr[grant_idx_reg];
            tx_srcport = srcport_arr[grant_idx_reg];
            tx_length  = length_arr[grant_idx_reg];
            tx_dstip   = dstip_arr[grant_idx_reg];
            tx_dstport = (SCPORT_OVERRIDE && (grant_idx_reg != '0))
                         ? cfg_scport : dstport_arr[grant_idx_reg];
        end
    end

    assign src_ack     = src_ack_reg;
    assign tx_req      = tx_req_reg;
    assign grant_idx   = grant_idx_reg;
    assign timeout_err = timeout_err_reg;

endmodule
